// File: rtl/reg_status_ctrl.sv
// Register status / rename controller: per-register busy+tag scoreboard between
// dispatch, ROB commit and the architectural register file, with flush recovery.
module reg_status_ctrl #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int TAG_WIDTH  = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic [TAG_WIDTH-1:0]  issue_tag,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic [TAG_WIDTH-1:0]  rs1_tag,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic                  rs2_busy,
  output logic [TAG_WIDTH-1:0]  rs2_tag,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  commit_valid,
  input  logic [ADDR_WIDTH-1:0] commit_rd,
  input  logic [TAG_WIDTH-1:0]  commit_tag,
  input  logic [DATA_WIDTH-1:0] commit_data,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] rf_read_addr1,
  output logic [ADDR_WIDTH-1:0] rf_read_addr2,
  input  logic [DATA_WIDTH-1:0] rf_read_data1,
  input  logic [DATA_WIDTH-1:0] rf_read_data2,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data
);

  typedef enum logic {RUN, RECOVER} state_t;

  typedef struct packed {
    logic                  busy;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } operand_t;

  state_t                state, state_next;
  logic [NUM_REGS-1:0]   busy;
  logic [TAG_WIDTH-1:0]  tag [NUM_REGS];
  logic                  issue_fire;
  operand_t              op1, op2;

  assign issue_ready = (state == RUN) && !flush;
  assign issue_fire  = issue_valid && issue_ready;

  assign rf_write_enable = commit_valid && (commit_rd != '0);
  assign rf_write_addr   = commit_rd;
  assign rf_write_data   = commit_data;
  assign rf_read_addr1   = rs1_addr;
  assign rf_read_addr2   = rs2_addr;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RECOVER;
    else     state <= state_next;
  end

  // NOTE: assign a default before any branch so the combinational block cannot infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush) state_next = RECOVER;
      RECOVER: state_next = flush ? RECOVER : RUN;
      default: state_next = RECOVER;
    endcase
  end

  // NOTE: the status table is small and must start clean, so it is reset like ordinary flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      for (int i = 0; i < NUM_REGS; i++) tag[i] <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      if (commit_valid && busy[commit_rd] && (tag[commit_rd] == commit_tag))
        busy[commit_rd] <= 1'b0;
      // Later assignment wins, so an issue to the committing rd keeps it busy.
      if (issue_fire && (issue_rd != '0)) begin
        busy[issue_rd] <= 1'b1;
        tag[issue_rd]  <= issue_tag;
      end
    end
  end

  function automatic operand_t lookup(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  busy_bit,
    input logic [TAG_WIDTH-1:0]  tag_val,
    input logic [DATA_WIDTH-1:0] rf_data
  );
    operand_t r;
    r.busy = 1'b0;
    r.tag  = '0;
    r.data = rf_data;
    if (addr == '0) begin
      r.data = '0;
    end else if (busy_bit) begin
      if (commit_valid && (commit_rd == addr) && (commit_tag == tag_val)) begin
        r.data = commit_data;
      end else begin
        r.busy = 1'b1;
        r.tag  = tag_val;
      end
    end
    return r;
  endfunction

  always_comb begin
    op1 = lookup(rs1_addr, busy[rs1_addr], tag[rs1_addr], rf_read_data1);
    op2 = lookup(rs2_addr, busy[rs2_addr], tag[rs2_addr], rf_read_data2);
  end

  assign rs1_busy = op1.busy;
  assign rs1_tag  = op1.tag;
  assign rs1_data = op1.data;
  assign rs2_busy = op2.busy;
  assign rs2_tag  = op2.tag;
  assign rs2_data = op2.data;

endmodule

// File: tb/tb_reg_status_ctrl.sv
// Scoreboard bench for reg_status_ctrl with a behavioural register file model.
module tb_reg_status_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rd, issue_tag;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic [4:0]  rs1_tag, rs2_tag;
  logic [31:0] rs1_data, rs2_data;
  logic        commit_valid;
  logic [4:0]  commit_rd, commit_tag;
  logic [31:0] commit_data;
  logic        flush;
  logic [4:0]  rf_read_addr1, rf_read_addr2;
  logic [31:0] rf_read_data1, rf_read_data2;
  logic        rf_write_enable;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;

  always #5 clk = ~clk;

  reg_status_ctrl dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rd(issue_rd), .issue_tag(issue_tag),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_data(rs1_data),
    .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_data(rs2_data),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_tag(commit_tag), .commit_data(commit_data),
    .flush(flush),
    .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data)
  );

  logic [31:0] rf_mem [32];
  initial for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000 + i;
  always @(posedge clk) if (rf_write_enable) rf_mem[rf_write_addr] <= rf_write_data;
  assign rf_read_data1 = rf_mem[rf_read_addr1];
  assign rf_read_data2 = rf_mem[rf_read_addr2];

  typedef enum {S_READY, S_RS1_BUSY, S_RS1_TAG, S_RS1_DATA,
                S_RS2_BUSY, S_RS2_TAG, S_RS2_DATA, S_WE, S_WADDR, S_WDATA} sel_e;
  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input sel_e s);
    case (s)
      S_READY:    return {31'd0, issue_ready};
      S_RS1_BUSY: return {31'd0, rs1_busy};
      S_RS1_TAG:  return {27'd0, rs1_tag};
      S_RS1_DATA: return rs1_data;
      S_RS2_BUSY: return {31'd0, rs2_busy};
      S_RS2_TAG:  return {27'd0, rs2_tag};
      S_RS2_DATA: return rs2_data;
      S_WE:       return {31'd0, rf_write_enable};
      S_WADDR:    return {27'd0, rf_write_addr};
      S_WDATA:    return rf_write_data;
      default:    return 32'hx;
    endcase
  endfunction

  task automatic expect_val(input string name, input sel_e s, input logic [31:0] v);
    exp_t e;
    e.name = name; e.sel = s; e.value = v;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.name, observe(e.sel), e.value);
    end
  endtask

  // Start each cycle at the falling edge with all stimulus idle.
  task automatic step(input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    issue_valid = 1'b0; issue_rd = '0; issue_tag = '0;
    commit_valid = 1'b0; commit_rd = '0; commit_tag = '0; commit_data = '0;
    flush = 1'b0;
    rs1_addr = a1; rs2_addr = a2;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [4:0] t);
    issue_valid = 1'b1; issue_rd = rd; issue_tag = t;
  endtask

  task automatic do_commit(input logic [4:0] rd, input logic [4:0] t, input logic [31:0] d);
    commit_valid = 1'b1; commit_rd = rd; commit_tag = t; commit_data = d;
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0; issue_rd = '0; issue_tag = '0;
    commit_valid = 1'b0; commit_rd = '0; commit_tag = '0; commit_data = '0;
    flush = 1'b0; rs1_addr = '0; rs2_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Recovery cycle right after reset.
    rs2_addr = 5'd5;
    expect_val("rst_ready", S_READY, 0);
    expect_val("rst_rs1_busy", S_RS1_BUSY, 0);
    expect_val("rst_rs1_x0", S_RS1_DATA, 0);
    expect_val("rst_rs2_busy", S_RS2_BUSY, 0);
    expect_val("rst_rs2_data", S_RS2_DATA, 32'h1005);
    drain();

    // Issue x5/tag3; same-cycle lookup still sees x5 free.
    step(5'd5, 5'd0);
    do_issue(5'd5, 5'd3);
    expect_val("run_ready", S_READY, 1);
    expect_val("iss5_same_busy", S_RS1_BUSY, 0);
    drain();

    step(5'd5, 5'd0);
    expect_val("x5_busy", S_RS1_BUSY, 1);
    expect_val("x5_tag", S_RS1_TAG, 3);
    drain();

    step(5'd5, 5'd5);
    do_commit(5'd5, 5'd3, 32'hDEADBEEF);
    expect_val("x5_byp_busy", S_RS1_BUSY, 0);
    expect_val("x5_byp_data", S_RS1_DATA, 32'hDEADBEEF);
    expect_val("x5_byp_data2", S_RS2_DATA, 32'hDEADBEEF);
    expect_val("x5_we", S_WE, 1);
    expect_val("x5_waddr", S_WADDR, 5);
    expect_val("x5_wdata", S_WDATA, 32'hDEADBEEF);
    drain();

    step(5'd5, 5'd0);
    expect_val("x5_after_busy", S_RS1_BUSY, 0);
    expect_val("x5_after_data", S_RS1_DATA, 32'hDEADBEEF);
    expect_val("idle_we", S_WE, 0);
    drain();

    // Stale-tag commit on x7.
    step(5'd0, 5'd0); do_issue(5'd7, 5'd1); drain();
    step(5'd0, 5'd0); do_issue(5'd7, 5'd2); drain();
    step(5'd7, 5'd0);
    do_commit(5'd7, 5'd1, 32'h11);
    expect_val("x7_stale_busy", S_RS1_BUSY, 1);
    expect_val("x7_stale_tag", S_RS1_TAG, 2);
    expect_val("x7_we", S_WE, 1);
    drain();
    step(5'd0, 5'd7);
    expect_val("x7_still_busy", S_RS2_BUSY, 1);
    expect_val("x7_still_tag", S_RS2_TAG, 2);
    expect_val("x7_rf", S_RS2_DATA, 32'h11);
    drain();

    // Same-cycle commit and issue on x9: issue wins.
    step(5'd0, 5'd0); do_issue(5'd9, 5'd4); drain();
    step(5'd9, 5'd0);
    do_commit(5'd9, 5'd4, 32'h99);
    do_issue(5'd9, 5'd6);
    expect_val("x9_byp_busy", S_RS1_BUSY, 0);
    expect_val("x9_byp_data", S_RS1_DATA, 32'h99);
    drain();
    step(5'd9, 5'd0);
    expect_val("x9_busy", S_RS1_BUSY, 1);
    expect_val("x9_tag", S_RS1_TAG, 6);
    expect_val("x9_rf", S_RS1_DATA, 32'h99);
    drain();

    // Flush with busy x3/x4/x10 and a concurrent commit to x3.
    step(5'd0, 5'd0); do_issue(5'd3, 5'd10); drain();
    step(5'd0, 5'd0); do_issue(5'd4, 5'd11); drain();
    step(5'd0, 5'd0); do_issue(5'd10, 5'd12); drain();
    step(5'd3, 5'd4);
    flush = 1'b1;
    do_commit(5'd3, 5'd10, 32'h55);
    do_issue(5'd11, 5'd13);
    expect_val("fl_ready", S_READY, 0);
    expect_val("fl_x3_byp", S_RS1_DATA, 32'h55);
    expect_val("fl_x4_busy", S_RS2_BUSY, 1);
    expect_val("fl_we", S_WE, 1);
    drain();
    step(5'd3, 5'd4);
    do_issue(5'd12, 5'd14);
    expect_val("rec_ready", S_READY, 0);
    expect_val("rec_x3_busy", S_RS1_BUSY, 0);
    expect_val("rec_x3_data", S_RS1_DATA, 32'h55);
    expect_val("rec_x4_busy", S_RS2_BUSY, 0);
    drain();
    step(5'd12, 5'd10);
    expect_val("post_ready", S_READY, 1);
    expect_val("post_x12_busy", S_RS1_BUSY, 0);
    expect_val("post_x10_busy", S_RS2_BUSY, 0);
    drain();
    step(5'd11, 5'd9);
    expect_val("post_x11_busy", S_RS1_BUSY, 0);
    expect_val("post_x9_busy", S_RS2_BUSY, 0);
    drain();

    // x0 is never renamed or written.
    step(5'd0, 5'd0);
    do_issue(5'd0, 5'd2);
    do_commit(5'd0, 5'd2, 32'h77);
    expect_val("x0_we", S_WE, 0);
    drain();
    step(5'd0, 5'd0);
    expect_val("x0_busy", S_RS1_BUSY, 0);
    expect_val("x0_tag", S_RS1_TAG, 0);
    expect_val("x0_data", S_RS1_DATA, 0);
    drain();

    // Flush arriving during recovery extends it by one cycle.
    step(5'd0, 5'd0); do_issue(5'd6, 5'd7); drain();
    step(5'd0, 5'd0); flush = 1'b1; drain();
    step(5'd6, 5'd0);
    flush = 1'b1;
    expect_val("fl2_ready", S_READY, 0);
    expect_val("fl2_x6_busy", S_RS1_BUSY, 0);
    drain();
    step(5'd0, 5'd0);
    expect_val("fl2_rec_ready", S_READY, 0);
    drain();
    step(5'd0, 5'd0);
    expect_val("fl2_run_ready", S_READY, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
